tube_scan_ctrl: RTL



---
 rtl/tube_pkg.sv | 37 +++
 rtl/tube_seg_decoder.sv | 16 +
 rtl/tube_scan_ctrl.sv | 118 +++++++++++
 3 files changed

// File: rtl/tube_pkg.sv
// Shared definitions for the seven-segment scan controller.
// Holds the register offsets, the CTRL field positions, the blank pattern,
// the hex-to-segment table and a byte-merge helper for partial writes.
package tube_pkg;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_AUX  = 2'd1;
    localparam logic [1:0] ADDR_CTRL = 2'd2;

    localparam int CTRL_EN       = 0;
    localparam int CTRL_BLANK_LO = 8;
    localparam int CTRL_BLANK_HI = 15;

    // Only EN and the BLANK mask exist in CTRL; every other bit reads 0.
    localparam logic [31:0] CTRL_MASK = 32'h0000_FF01;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Active-low {dp,g,f,e,d,c,b,a}; element [0] is the rightmost entry.
    localparam logic [15:0][7:0] SEG_TABLE = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    // Replace only the bytes whose enable bit is set.
    function automatic logic [31:0] merge_bytes(input logic [31:0] cur,
                                                input logic [31:0] wd,
                                                input logic [3:0]  be);
        logic [31:0] r;
        r = cur;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/tube_seg_decoder.sv
// Combinational hex digit to seven-segment decoder.
// Ports:
//   nibble : 4-bit hex value to display
//   blank  : when 1, all segments off
//   seg    : active-low segments {dp,g,f,e,d,c,b,a}; dp is always off
module tube_seg_decoder
    import tube_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [7:0] seg
);

    assign seg = blank ? SEG_OFF : SEG_TABLE[nibble];

endmodule

// File: rtl/tube_scan_ctrl.sv
// Memory-mapped scan controller for two 4-digit tube groups plus one aux digit.
// Ports:
//   clk, reset          : system clock, synchronous active-high reset
//   we, addr, byte_en,
//   wdata               : register write port (0 DATA, 1 AUX, 2 CTRL, 3 reserved)
//   rdata               : combinational read of the register selected by addr
//   digital_tube0/1/2   : active-low segments for group 0, group 1, aux digit
//   digital_tube_sel0/1 : one-hot active-high digit selects (shared index)
//   digital_tube_sel2   : aux digit select, follows EN
module tube_scan_ctrl
    import tube_pkg::*;
#(
    parameter int          SCAN_DIV   = 25000,
    parameter logic [31:0] RESET_CTRL = 32'h0000_0001
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [1:0]  addr,
    input  logic [3:0]  byte_en,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [7:0]  digital_tube0,
    output logic [3:0]  digital_tube_sel0,
    output logic [7:0]  digital_tube1,
    output logic [3:0]  digital_tube_sel1,
    output logic [7:0]  digital_tube2,
    output logic        digital_tube_sel2
);

    localparam logic [19:0] PRE_LAST = 20'(SCAN_DIV - 1);

    logic [31:0] data;
    logic [3:0]  aux;
    logic [31:0] ctrl;
    logic [19:0] pre;
    logic [1:0]  idx;

    logic       en;
    logic [7:0] blank;
    logic [3:0] nib0, nib1;
    logic [7:0] seg0, seg1, seg2;

    assign en    = ctrl[CTRL_EN];
    assign blank = ctrl[CTRL_BLANK_HI:CTRL_BLANK_LO];

    // Group 0 shows digits 0..3 of DATA, group 1 digits 4..7, same idx.
    assign nib0 = data[{idx, 2'b00} +: 4];
    assign nib1 = data[{1'b1, idx, 2'b00} +: 4];

    tube_seg_decoder u_dec0 (.nibble(nib0), .blank(blank[{1'b0, idx}]), .seg(seg0));
    tube_seg_decoder u_dec1 (.nibble(nib1), .blank(blank[{1'b1, idx}]), .seg(seg1));
    tube_seg_decoder u_dec2 (.nibble(aux),  .blank(1'b0),               .seg(seg2));

    always_comb begin
        rdata = 32'h0;
        case (addr)
            ADDR_DATA: rdata = data;
            ADDR_AUX:  rdata = {28'h0, aux};
            ADDR_CTRL: rdata = ctrl;
            default:   rdata = 32'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data              <= 32'h0;
            aux               <= 4'h0;
            ctrl              <= RESET_CTRL & CTRL_MASK;
            pre               <= 20'h0;
            idx               <= 2'd0;
            digital_tube0     <= SEG_OFF;
            digital_tube1     <= SEG_OFF;
            digital_tube2     <= SEG_OFF;
            digital_tube_sel0 <= 4'b0000;
            digital_tube_sel1 <= 4'b0000;
            digital_tube_sel2 <= 1'b0;
        end else begin
            // Outputs reflect this cycle's registers and idx, one cycle late.
            if (en) begin
                digital_tube0     <= seg0;
                digital_tube1     <= seg1;
                digital_tube2     <= seg2;
                digital_tube_sel0 <= 4'b0001 << idx;
                digital_tube_sel1 <= 4'b0001 << idx;
                digital_tube_sel2 <= 1'b1;
            end else begin
                digital_tube0     <= SEG_OFF;
                digital_tube1     <= SEG_OFF;
                digital_tube2     <= SEG_OFF;
                digital_tube_sel0 <= 4'b0000;
                digital_tube_sel1 <= 4'b0000;
                digital_tube_sel2 <= 1'b0;
            end

            // Holding pre/idx at 0 while disabled gives a full first period on re-enable.
            if (!en) begin
                pre <= 20'h0;
                idx <= 2'd0;
            end else if (pre == PRE_LAST) begin
                pre <= 20'h0;
                idx <= idx + 2'd1;
            end else begin
                pre <= pre + 20'h1;
            end

            if (we) begin
                case (addr)
                    ADDR_DATA: data <= merge_bytes(data, wdata, byte_en);
                    ADDR_AUX:  aux  <= merge_bytes({28'h0, aux}, wdata, byte_en) & 32'hF;
                    ADDR_CTRL: ctrl <= merge_bytes(ctrl, wdata, byte_en) & CTRL_MASK;
                    default:   ;
                endcase
            end
        end
    end

endmodule
